ili9341_scanout: RTL and testbench
==================================

# ili9341_scanout

Display-side scanout engine for the ILI9341 video path. It owns the frame schedule: it reads 8-bit RGB332 pixels from the external SRAM through the SPI video memory controller's read port (`display_x`/`display_y`/`memory_read`) and streams them to the ILI9341 over the 8-bit 8080 parallel bus as RGB565. It also drives `memory_write_allowed` so that SPI-fed writes reach the SRAM only while the bus is not being read.

## Interface
- `DISPLAY_WIDTH`, 240, pixels per row.
- `DISPLAY_HEIGHT`, 320, rows per frame.
- `WIDTH_BITS`, `$clog2(DISPLAY_WIDTH)`, x coordinate width.
- `HEIGHT_BITS`, `$clog2(DISPLAY_HEIGHT)`, y coordinate width.
- `GAP_CYCLES`, 1024, inter-frame write window in cycles; must be ≥ 2.

Ports:
- `read_clk`  in  1  the block's single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  high = run frames continuously.
- `display_x`  out  WIDTH_BITS  pixel column to fetch.
- `display_y`  out  HEIGHT_BITS  pixel row to fetch.
- `memory_read`  out  1  SRAM bus owned by scanout; controller tri-states data.
- `memory_data`  in  8  SRAM read data, RGB332: [7:5]=R, [4:2]=G, [1:0]=B.
- `memory_write_allowed`  out  1  controller may issue SRAM writes.
- `lcd_cs_n`, `lcd_dc`, `lcd_wr_n`, `lcd_rd_n`  out  1 each  ILI9341 8080 strobes.
- `lcd_data`  out  8  ILI9341 data bus.
- `frame_done`  out  1  one-cycle pulse after the last pixel byte.

## Operation
- All outputs are registered.
- FSM states and transitions:
  - IDLE: go to HEADER when `enable`=1.
  - HEADER: send 11 bytes, then go to PREFETCH.
  - PREFETCH: lasts 2 cycles, then go to STREAM.
  - STREAM: send W·H pixels, then go to GAP.
  - GAP: lasts `GAP_CYCLES` cycles, then go to HEADER if `enable`=1, else IDLE.
- `enable` is sampled only in IDLE and on the last GAP cycle. Deasserting it mid-frame lets the frame finish.
- HEADER byte sequence (`lcd_dc`=0 for commands, 1 for parameters):
  - 0x2A, then 0x00, 0x00, (W−1)[15:8], (W−1)[7:0].
  - 0x2B, then 0x00, 0x00, (H−1)[15:8], (H−1)[7:0].
  - 0x2C.
- Byte write takes 2 cycles:
  - Cycle A: `lcd_data`/`lcd_dc` valid, `lcd_wr_n`=0.
  - Cycle B: `lcd_wr_n`=1; the LCD latches on this rising edge.
  - Data and dc are held through cycle B.
- `lcd_rd_n` is always 1.
- `lcd_cs_n`=0 from the first HEADER cycle through the last STREAM cycle; 1 otherwise.
- Pixel conversion:
  - R5={r,r[2:1]}, G6={g,g}, B5={b,b,b[1]}.
  - First (high) byte is {R5,G6[5:3]}; second (low) byte is {G6[2:0],B5}; `lcd_dc`=1 for both.
- Address and fetch pipeline:
  - `memory_read`=1 throughout PREFETCH and STREAM, 0 otherwise.
  - On PREFETCH entry the address is (0,0).
  - At the end of PREFETCH, latch `memory_data` as pixel 0 and advance the address.
  - In STREAM, each pixel takes 4 cycles (phases 0–3: hi A, hi B, lo A, lo B). During these phases the address holds pixel n+1.
  - At the end of phase 3, latch `memory_data` as the next pixel and advance the address.
- Address advance: x increments; at x=W−1, x wraps to 0 and y increments. After (W−1,H−1) the address wraps to (0,0); the fetch latched for that address is discarded.
- `memory_write_allowed` has a one-cycle guard on each side of `memory_read`:
  - 0 on the last HEADER cycle, through PREFETCH and STREAM, and on the first GAP cycle.
  - 1 in IDLE, the rest of GAP, and HEADER except its last cycle.

## Timing
- Reset values:
  - `lcd_cs_n`=1, `lcd_wr_n`=1, `lcd_rd_n`=1, `lcd_dc`=1, `lcd_data`=0.
  - `memory_read`=0, `memory_write_allowed`=0, `display_x`/`display_y`=0, `frame_done`=0.
  - State is IDLE.
  - `memory_write_allowed` rises on the first cycle after `reset` deasserts.
- Reset asserted mid-frame: next edge forces the reset values. No partial byte is completed; `lcd_cs_n` rises at once.
- Frame length from HEADER entry to `frame_done`: 22 + 2 + 4·W·H cycles, which is 307224 at default parameters.
- `frame_done` pulses on the first GAP cycle.
- SRAM access window: the address is stable ≥ 4 cycles before data is latched (≥ 2 cycles in PREFETCH).

## Test plan
- Reset, hold `enable`=0 for 100 cycles → strobes idle-high, `memory_read`=0, `memory_write_allowed`=1 from the cycle after reset release.
- `enable`=1, capture bus on `lcd_wr_n` rising edges → first 11 bytes are 2A 00 00 00 EF 2B 00 00 01 3F 2C with dc=0 only on 2A/2B/2C.
- SRAM model returns 0xE0, 0x1C, 0x03, 0xFF for pixels 0–3 → LCD receives F8 00, 07 E0, 00 1F, FF FF.
- W=4, H=3, SRAM data = x+16·y → 12 pixels in raster order, address wraps to (0,0), `frame_done` one pulse at cycle 24+48 after HEADER entry.
- Check `memory_write_allowed` against `memory_read` → every `memory_read` high cycle has `memory_write_allowed`=0 on it and on the cycle before and after.
- Assert `reset` during STREAM phase 2 → next edge all outputs at reset values, state IDLE; with `enable`=1, a new full frame starts with the HEADER.

Source files
------------

// File: rtl/ili9341_scanout.sv
// ILI9341 scanout engine: fetches RGB332 pixels from SRAM and streams them to the LCD
// 8080 bus as RGB565, and gates SPI-fed SRAM writes around the read window.
module ili9341_scanout #(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int WIDTH_BITS     = $clog2(DISPLAY_WIDTH),
  parameter int HEIGHT_BITS    = $clog2(DISPLAY_HEIGHT),
  parameter int GAP_CYCLES     = 1024
) (
  input  logic                   read_clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic [WIDTH_BITS-1:0]  display_x,
  output logic [HEIGHT_BITS-1:0] display_y,
  output logic                   memory_read,
  input  logic [7:0]             memory_data,
  output logic                   memory_write_allowed,
  output logic                   lcd_cs_n,
  output logic                   lcd_dc,
  output logic                   lcd_wr_n,
  output logic                   lcd_rd_n,
  output logic [7:0]             lcd_data,
  output logic                   frame_done
);

  // state      | meaning
  // S_IDLE     | waiting for enable, SRAM writes allowed
  // S_HEADER   | column/page window + memory-write command bytes
  // S_PREFETCH | two-cycle SRAM read of pixel 0
  // S_STREAM   | four cycles per pixel: hi A, hi B, lo A, lo B
  // S_GAP      | inter-frame SRAM write window

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PREFETCH,
    S_STREAM,
    S_GAP
  } state_t;

  localparam int NUM_PIXELS = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int TIMER_MAX  = (NUM_PIXELS > GAP_CYCLES) ? NUM_PIXELS : GAP_CYCLES;
  localparam int TIMER_BITS = $clog2(TIMER_MAX);
  localparam logic [3:0]  HDR_LAST = 4'd10;
  localparam logic [15:0] W_M1 = 16'(DISPLAY_WIDTH - 1);
  localparam logic [15:0] H_M1 = 16'(DISPLAY_HEIGHT - 1);

  state_t                state;
  logic [3:0]            hdr_idx;
  logic [1:0]            phase;
  logic [TIMER_BITS-1:0] timer;
  logic [7:0]            pix;
  logic [WIDTH_BITS-1:0]  adv_x;
  logic [HEIGHT_BITS-1:0] adv_y;
  logic                  go_header;

  function automatic logic [8:0] hdr_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return {1'b0, 8'h2A};
      4'd3:    return {1'b1, W_M1[15:8]};
      4'd4:    return {1'b1, W_M1[7:0]};
      4'd5:    return {1'b0, 8'h2B};
      4'd8:    return {1'b1, H_M1[15:8]};
      4'd9:    return {1'b1, H_M1[7:0]};
      4'd10:   return {1'b0, 8'h2C};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  function automatic logic [7:0] hi_byte(input logic [7:0] p);
    return {p[7:5], p[7:6], p[4:2]};
  endfunction

  function automatic logic [7:0] lo_byte(input logic [7:0] p);
    return {p[4:2], p[1:0], p[1:0], p[1]};
  endfunction

  // Raster-order address advance, wrapping to (0,0) after the last pixel.
  always_comb begin
    adv_x = display_x + 1'b1;
    adv_y = display_y;
    if (display_x == WIDTH_BITS'(DISPLAY_WIDTH - 1)) begin
      adv_x = '0;
      adv_y = (display_y == HEIGHT_BITS'(DISPLAY_HEIGHT - 1)) ? '0 : display_y + 1'b1;
    end
  end

  assign go_header = enable && (state == S_IDLE || (state == S_GAP && timer == '0));

  always_ff @(posedge read_clk) begin
    if (reset) begin
      state                <= S_IDLE;
      hdr_idx              <= '0;
      phase                <= '0;
      timer                <= '0;
      pix                  <= '0;
      display_x            <= '0;
      display_y            <= '0;
      memory_read          <= 1'b0;
      memory_write_allowed <= 1'b0;
      lcd_cs_n             <= 1'b1;
      lcd_wr_n             <= 1'b1;
      lcd_rd_n             <= 1'b1;
      lcd_dc               <= 1'b1;
      lcd_data             <= '0;
      frame_done           <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      lcd_rd_n   <= 1'b1;
      case (state)
        S_IDLE: begin
          memory_write_allowed <= 1'b1;
        end
        S_HEADER: begin
          if (!lcd_wr_n) begin
            lcd_wr_n <= 1'b1;
            if (hdr_idx == HDR_LAST) memory_write_allowed <= 1'b0;
          end else if (hdr_idx == HDR_LAST) begin
            state       <= S_PREFETCH;
            timer       <= TIMER_BITS'(1);
            memory_read <= 1'b1;
            display_x   <= '0;
            display_y   <= '0;
          end else begin
            hdr_idx              <= hdr_idx + 4'd1;
            lcd_wr_n             <= 1'b0;
            {lcd_dc, lcd_data}   <= hdr_byte(hdr_idx + 4'd1);
          end
        end
        S_PREFETCH: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            state     <= S_STREAM;
            timer     <= TIMER_BITS'(NUM_PIXELS - 1);
            phase     <= 2'd0;
            pix       <= memory_data;
            display_x <= adv_x;
            display_y <= adv_y;
            lcd_wr_n  <= 1'b0;
            lcd_dc    <= 1'b1;
            lcd_data  <= hi_byte(memory_data);
          end
        end
        S_STREAM: begin
          phase <= phase + 2'd1;
          case (phase)
            2'd0: lcd_wr_n <= 1'b1;
            2'd1: begin
              lcd_wr_n <= 1'b0;
              lcd_data <= lo_byte(pix);
            end
            2'd2: lcd_wr_n <= 1'b1;
            default: begin
              // The read issued at the wrapped (0,0) address is dropped here.
              if (timer == '0) begin
                state       <= S_GAP;
                timer       <= TIMER_BITS'(GAP_CYCLES - 1);
                memory_read <= 1'b0;
                lcd_cs_n    <= 1'b1;
                frame_done  <= 1'b1;
              end else begin
                timer     <= timer - 1'b1;
                pix       <= memory_data;
                display_x <= adv_x;
                display_y <= adv_y;
                lcd_wr_n  <= 1'b0;
                lcd_data  <= hi_byte(memory_data);
              end
            end
          endcase
        end
        S_GAP: begin
          memory_write_allowed <= 1'b1;
          if (timer != '0) timer <= timer - 1'b1;
          else state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (go_header) begin
        state                <= S_HEADER;
        hdr_idx              <= '0;
        lcd_cs_n             <= 1'b0;
        lcd_wr_n             <= 1'b0;
        {lcd_dc, lcd_data}   <= hdr_byte(4'd0);
        memory_write_allowed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ili9341_scanout.sv
// Bench for ili9341_scanout: a full-size instance for header/pixel/reset checks and a
// 4x3 instance for complete frames, checked against a cycle-window schedule model.
module tb_ili9341_scanout;
  localparam int WB = 4;
  localparam int HB = 3;
  localparam int GB = 8;
  localparam int PB = 24 + 4 * WB * HB + GB;

  logic read_clk = 1'b0;
  logic reset = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  always #5 read_clk = ~read_clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] seed_a = 8'h00;
  logic [7:0] mem_b_arr [16];

  logic [7:0] a_x;
  logic [8:0] a_y;
  logic a_memory_read, a_mwa, a_cs_n, a_dc, a_wr_n, a_rd_n, a_frame_done;
  logic [7:0] a_data, a_mem;
  logic [1:0] b_x, b_y;
  logic b_memory_read, b_mwa, b_cs_n, b_dc, b_wr_n, b_rd_n, b_frame_done;
  logic [7:0] b_data, b_mem;

  ili9341_scanout dut_a (
    .read_clk(read_clk), .reset(reset), .enable(en_a),
    .display_x(a_x), .display_y(a_y), .memory_read(a_memory_read),
    .memory_data(a_mem), .memory_write_allowed(a_mwa),
    .lcd_cs_n(a_cs_n), .lcd_dc(a_dc), .lcd_wr_n(a_wr_n), .lcd_rd_n(a_rd_n),
    .lcd_data(a_data), .frame_done(a_frame_done)
  );

  ili9341_scanout #(.DISPLAY_WIDTH(WB), .DISPLAY_HEIGHT(HB), .GAP_CYCLES(GB)) dut_b (
    .read_clk(read_clk), .reset(reset), .enable(en_b),
    .display_x(b_x), .display_y(b_y), .memory_read(b_memory_read),
    .memory_data(b_mem), .memory_write_allowed(b_mwa),
    .lcd_cs_n(b_cs_n), .lcd_dc(b_dc), .lcd_wr_n(b_wr_n), .lcd_rd_n(b_rd_n),
    .lcd_data(b_data), .frame_done(b_frame_done)
  );

  function automatic logic [7:0] mem_a_val(input int x, input int y, input logic [7:0] seed);
    if (y == 0 && x < 4) begin
      case (x)
        0: return 8'hE0;
        1: return 8'h1C;
        2: return 8'h03;
        default: return 8'hFF;
      endcase
    end
    return 8'((x * 37 + y * 11 + int'(seed)) % 256);
  endfunction

  always_comb a_mem = mem_a_val(int'(a_x), int'(a_y), seed_a);
  always_comb b_mem = mem_b_arr[int'(b_y) * WB + int'(b_x)];

  function automatic logic [15:0] rgb565(input logic [7:0] d);
    int r, g, b, r5, g6, b5;
    r = int'(d) / 32;
    g = (int'(d) / 4) % 8;
    b = int'(d) % 4;
    r5 = r * 4 + r / 2;
    g6 = g * 8 + g;
    b5 = b * 8 + b * 2 + b / 2;
    return 16'(r5 * 2048 + g6 * 32 + b5);
  endfunction

  function automatic logic [8:0] hdr_model(input int k, input int w, input int h);
    case (k)
      0:  return 9'h02A;
      5:  return 9'h02B;
      10: return 9'h02C;
      3:  return {1'b1, 8'((w - 1) / 256)};
      4:  return {1'b1, 8'((w - 1) % 256)};
      8:  return {1'b1, 8'((h - 1) / 256)};
      9:  return {1'b1, 8'((h - 1) % 256)};
      default: return 9'h100;
    endcase
  endfunction

  function automatic logic [8:0] exp_byte_a(input int k);
    int j, p;
    logic [15:0] c;
    if (k < 11) return hdr_model(k, 240, 320);
    j = k - 11;
    p = j / 2;
    c = rgb565(mem_a_val(p % 240, p / 240, seed_a));
    return (j % 2 == 0) ? {1'b1, c[15:8]} : {1'b1, c[7:0]};
  endfunction

  function automatic logic [8:0] exp_byte_b(input int k);
    int j;
    logic [15:0] c;
    if (k < 11) return hdr_model(k, WB, HB);
    j = k - 11;
    c = rgb565(mem_b_arr[j / 2]);
    return (j % 2 == 0) ? {1'b1, c[15:8]} : {1'b1, c[7:0]};
  endfunction

  task automatic test_reset();
    reset = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (2) @(negedge read_clk);
    vectors++;
    if ({a_cs_n, a_wr_n, a_rd_n, a_dc, a_data, a_memory_read, a_mwa, a_frame_done, a_x, a_y} !== 32'hF000_0000) begin
      miscompares++;
      $display("FAIL reset_vals_a got cs%b wr%b rd%b dc%b d%h mr%b mwa%b fd%b x%0d y%0d want 1111 00 000 0 0",
               a_cs_n, a_wr_n, a_rd_n, a_dc, a_data, a_memory_read, a_mwa, a_frame_done, a_x, a_y);
    end
    vectors++;
    if ({b_cs_n, b_wr_n, b_rd_n, b_dc, b_data, b_memory_read, b_mwa, b_frame_done, b_x, b_y} !== {4'hF, 15'h0}) begin
      miscompares++;
      $display("FAIL reset_vals_b got cs%b wr%b rd%b dc%b d%h mr%b mwa%b fd%b x%0d y%0d want 1111 00 000 0 0",
               b_cs_n, b_wr_n, b_rd_n, b_dc, b_data, b_memory_read, b_mwa, b_frame_done, b_x, b_y);
    end
    reset = 1'b0;
    @(negedge read_clk);
    vectors++;
    if ({a_mwa, b_mwa} !== 2'b11) begin
      miscompares++;
      $display("FAIL mwa_after_release got a=%b b=%b want 1 1", a_mwa, b_mwa);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge read_clk);
      vectors++;
      if ({a_cs_n, a_wr_n, a_rd_n, a_memory_read, a_mwa, b_cs_n, b_wr_n, b_rd_n, b_memory_read, b_mwa} !== 10'b11101_11101) begin
        miscompares++;
        $display("FAIL idle_strobes cyc=%0d got a=%b%b%b%b%b b=%b%b%b%b%b want 11101 11101", i,
                 a_cs_n, a_wr_n, a_rd_n, a_memory_read, a_mwa, b_cs_n, b_wr_n, b_rd_n, b_memory_read, b_mwa);
      end
    end
  endtask

  task automatic test_header_pixels();
    int k, idx;
    logic e_wr, e_rd, e_mwa;
    logic [8:0] eb;
    reset = 1'b1; en_a = 1'b0;
    @(negedge read_clk);
    reset = 1'b0;
    @(negedge read_clk);
    seed_a = 8'($urandom);
    en_a = 1'b1;
    for (int t = 0; t < 56; t++) begin
      @(negedge read_clk);
      e_wr  = !((t < 22 || t >= 24) && (t % 2 == 0));
      e_rd  = (t >= 22);
      e_mwa = (t < 21);
      vectors++;
      if ({a_cs_n, a_wr_n, a_rd_n, a_memory_read, a_mwa, a_frame_done} !== {1'b0, e_wr, 1'b1, e_rd, e_mwa, 1'b0}) begin
        miscompares++;
        $display("FAIL hdr_strobes t=%0d got cs%b wr%b rd%b mr%b mwa%b fd%b want cs0 wr%b rd1 mr%b mwa%b fd0",
                 t, a_cs_n, a_wr_n, a_rd_n, a_memory_read, a_mwa, a_frame_done, e_wr, e_rd, e_mwa);
      end
      if (t < 22 || t >= 24) begin
        k = (t < 22) ? t / 2 : 11 + (t - 24) / 2;
        eb = exp_byte_a(k);
        vectors++;
        if ({a_dc, a_data} !== eb) begin
          miscompares++;
          $display("FAIL lcd_byte_a t=%0d k=%0d got dc%b %h want dc%b %h", t, k, a_dc, a_data, eb[8], eb[7:0]);
        end
      end
      if (t >= 22) begin
        idx = (t < 24) ? 0 : (t - 24) / 4 + 1;
        vectors++;
        if ({a_x, a_y} !== {8'(idx % 240), 9'(idx / 240)}) begin
          miscompares++;
          $display("FAIL addr_a t=%0d got (%0d,%0d) want (%0d,%0d)", t, a_x, a_y, idx % 240, idx / 240);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] eb;
    reset = 1'b1; en_a = 1'b0;
    @(negedge read_clk);
    reset = 1'b0;
    @(negedge read_clk);
    en_a = 1'b1;
    for (int t = 0; t <= 46; t++) @(negedge read_clk);
    eb = exp_byte_a(11 + 5 * 2 + 1);
    vectors++;
    if ({a_wr_n, a_dc, a_data} !== {1'b0, eb}) begin
      miscompares++;
      $display("FAIL phase2_lo got wr%b dc%b %h want wr0 dc%b %h", a_wr_n, a_dc, a_data, eb[8], eb[7:0]);
    end
    reset = 1'b1;
    @(negedge read_clk);
    vectors++;
    if ({a_cs_n, a_wr_n, a_rd_n, a_dc, a_data, a_memory_read, a_mwa, a_frame_done, a_x, a_y} !== 32'hF000_0000) begin
      miscompares++;
      $display("FAIL midframe_reset got cs%b wr%b rd%b dc%b d%h mr%b mwa%b fd%b x%0d y%0d want 1111 00 000 0 0",
               a_cs_n, a_wr_n, a_rd_n, a_dc, a_data, a_memory_read, a_mwa, a_frame_done, a_x, a_y);
    end
    reset = 1'b0;
    @(negedge read_clk);
    vectors++;
    if ({a_cs_n, a_wr_n, a_dc, a_data, a_mwa, a_memory_read} !== {3'b000, 8'h2A, 2'b10}) begin
      miscompares++;
      $display("FAIL restart_hdr got cs%b wr%b dc%b %h mwa%b mr%b want cs0 wr0 dc0 2a mwa1 mr0",
               a_cs_n, a_wr_n, a_dc, a_data, a_mwa, a_memory_read);
    end
    @(negedge read_clk);
    vectors++;
    if ({a_cs_n, a_wr_n, a_dc, a_data} !== {3'b010, 8'h2A}) begin
      miscompares++;
      $display("FAIL restart_hold got cs%b wr%b dc%b %h want cs0 wr1 dc0 2a", a_cs_n, a_wr_n, a_dc, a_data);
    end
    en_a = 1'b0;
  endtask

  task automatic test_frame_b(input int nframes);
    int f, t, k, idx, total;
    logic e_cs, e_wr, e_rd, e_mwa, e_fd, prev_rd, prev_mwa;
    logic [8:0] eb;
    reset = 1'b1; en_a = 1'b0; en_b = 1'b0;
    @(negedge read_clk);
    reset = 1'b0;
    @(negedge read_clk);
    for (int i = 0; i < 16; i++) mem_b_arr[i] = 8'(i % WB + 16 * (i / WB));
    prev_rd = b_memory_read;
    prev_mwa = b_mwa;
    en_b = 1'b1;
    total = nframes * PB + 20;
    for (int c = 0; c < total; c++) begin
      @(negedge read_clk);
      f = c / PB;
      t = c % PB;
      if (f < nframes) begin
        e_cs = (t >= 72);
        e_rd = (t >= 22 && t < 72);
        e_mwa = !(t >= 21 && t <= 72);
        e_fd = (t == 72);
        e_wr = !((t < 22 || (t >= 24 && t < 72)) && (t % 2 == 0));
      end else begin
        e_cs = 1'b1; e_rd = 1'b0; e_mwa = 1'b1; e_fd = 1'b0; e_wr = 1'b1;
      end
      vectors++;
      if ({b_cs_n, b_wr_n, b_rd_n, b_memory_read, b_mwa, b_frame_done} !== {e_cs, e_wr, 1'b1, e_rd, e_mwa, e_fd}) begin
        miscompares++;
        $display("FAIL sched_b f=%0d t=%0d got cs%b wr%b rd%b mr%b mwa%b fd%b want cs%b wr%b rd1 mr%b mwa%b fd%b",
                 f, t, b_cs_n, b_wr_n, b_rd_n, b_memory_read, b_mwa, b_frame_done, e_cs, e_wr, e_rd, e_mwa, e_fd);
      end
      if (f < nframes && (t < 22 || (t >= 24 && t < 72))) begin
        k = (t < 22) ? t / 2 : 11 + (t - 24) / 2;
        eb = exp_byte_b(k);
        vectors++;
        if ({b_dc, b_data} !== eb) begin
          miscompares++;
          $display("FAIL lcd_byte_b f=%0d t=%0d k=%0d got dc%b %h want dc%b %h", f, t, k, b_dc, b_data, eb[8], eb[7:0]);
        end
      end
      if (f < nframes && t >= 22 && t <= 72) begin
        idx = (t < 24 || t == 72) ? 0 : ((t - 24) / 4 + 1) % (WB * HB);
        vectors++;
        if ({b_x, b_y} !== {2'(idx % WB), 2'(idx / WB)}) begin
          miscompares++;
          $display("FAIL addr_b f=%0d t=%0d got (%0d,%0d) want (%0d,%0d)", f, t, b_x, b_y, idx % WB, idx / WB);
        end
      end
      vectors++;
      if ((b_memory_read && (b_mwa || prev_mwa)) || (prev_rd && b_mwa)) begin
        miscompares++;
        $display("FAIL write_guard f=%0d t=%0d got mr%b mwa%b prev_mr%b prev_mwa%b want mwa low around reads",
                 f, t, b_memory_read, b_mwa, prev_rd, prev_mwa);
      end
      prev_rd = b_memory_read;
      prev_mwa = b_mwa;
      if (c == (nframes - 1) * PB + 10) en_b = 1'b0;
      if (t == 75 && f < nframes - 1)
        for (int i = 0; i < WB * HB; i++) mem_b_arr[i] = 8'($urandom);
    end
    en_b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_header_pixels();
    test_reset_midframe();
    test_frame_b(1);
    test_frame_b(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
